// File: rtl/neg_regfile.sv
// neg_regfile: multi-register file with one write port and two read ports. All
// stored state changes on the falling clock edge.
//
// Ports:
//   clk              single clock; registers and written flags change on its falling edge
//   clr_n            asynchronous active-low clear of all registers and written flags
//   sclr             synchronous clear-all, sampled on the falling edge; wins over a write
//   we               write enable
//   waddr            write address; writes to waddr >= DEPTH are dropped
//   wdata            write data
//   wmask            byte-lane write mask; bit i covers data bits [8i+7:8i]
//   raddr_a/raddr_b  combinational read addresses for ports A and B
//   oe_a/oe_b        output enables; when an enable is 0, that port floats (high-Z)
//   rdata_a/rdata_b  tri-state read data; reads at raddr >= DEPTH return zero
//   written          per-register flag, set once the register has been written since the last clear
//
// With ZERO_REG = 1, register 0 always reads as zero, ignores writes, and never sets its flag.
module neg_regfile #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       sclr,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [(WIDTH+7)/8-1:0]     wmask,
    input  logic [AW-1:0]              raddr_a,
    input  logic [AW-1:0]              raddr_b,
    input  logic                       oe_a,
    input  logic                       oe_b,
    output tri   [WIDTH-1:0]           rdata_a,
    output tri   [WIDTH-1:0]           rdata_b,
    output logic [DEPTH-1:0]           written
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_written;

    logic [WIDTH-1:0] w_bitmask;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Expand the byte-lane mask to a per-bit mask. When WIDTH is not a multiple of 8,
    // the top lane is partial.
    always_comb begin
        w_bitmask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_bitmask[b] = wmask[b/8];
        end
    end

    // Writes to register 0 are dropped here when it is hardwired. Out-of-range addresses
    // never match an entry in the loops below.
    assign w_wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written <= '0;
        end else if (sclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    // An all-zero mask still marks the register as written.
                    r_mem[i]     <= (r_mem[i] & ~w_bitmask) | (wdata & w_bitmask);
                    r_written[i] <= 1'b1;
                end
            end
        end
    end

    // Read muxes default to zero, so addresses with no matching entry read as zero.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                w_rd_a = r_mem[i];
            end
            if (raddr_b == AW'(i)) begin
                w_rd_b = r_mem[i];
            end
        end
    end

    assign rdata_a = oe_a ? w_rd_a : {WIDTH{1'bz}};
    assign rdata_b = oe_b ? w_rd_b : {WIDTH{1'bz}};
    assign written = r_written;

endmodule

// File: tb/tb_neg_regfile.sv
// Testbench for neg_regfile. One instance uses DEPTH=32 and a second uses DEPTH=20; both
// share the same stimulus. A behavioural array model supplies every expected value.
// The read nets are pulled up, so a floating (high-Z) port is expected to read as all ones.
module tb_neg_regfile;

    logic        clk = 1'b0;
    logic        clr_n, sclr, we, oe_a, oe_b;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [3:0]  wmask;

    tri1  [31:0] rd32_a, rd32_b, rd20_a, rd20_b;
    logic [31:0] wr32;
    logic [19:0] wr20;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m32 [32];
    logic [31:0] m20 [20];
    logic [31:0] mw32;
    logic [19:0] mw20;

    always #5 clk = ~clk;

    neg_regfile #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1)) dut32 (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .raddr_a(raddr_a), .raddr_b(raddr_b), .oe_a(oe_a), .oe_b(oe_b),
        .rdata_a(rd32_a), .rdata_b(rd32_b), .written(wr32)
    );

    neg_regfile #(.WIDTH(32), .DEPTH(20), .AW(5), .ZERO_REG(1)) dut20 (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .raddr_a(raddr_a), .raddr_b(raddr_b), .oe_a(oe_a), .oe_b(oe_b),
        .rdata_a(rd20_a), .rdata_b(rd20_b), .written(wr20)
    );

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) m32[i] = '0;
        for (int i = 0; i < 20; i++) m20[i] = '0;
        mw32 = '0;
        mw20 = '0;
    endtask

    // Model: registers clear as soon as clr_n falls. A write lands on a falling edge
    // unless reset or sclr is active.
    always @(negedge clr_n) mdl_clear();

    always @(negedge clk) begin
        if (!clr_n || sclr) begin
            mdl_clear();
        end else if (we && waddr != 0) begin
            for (int l = 0; l < 4; l++) begin
                if (wmask[l]) begin
                    if (waddr < 32) m32[waddr][8*l +: 8] = wdata[8*l +: 8];
                    if (waddr < 20) m20[waddr][8*l +: 8] = wdata[8*l +: 8];
                end
            end
            if (waddr < 32) mw32[waddr] = 1'b1;
            if (waddr < 20) mw20[waddr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp32(input logic [4:0] a, input logic oe);
        if (!oe) return 32'hFFFF_FFFF;
        return m32[a];
    endfunction

    function automatic logic [31:0] exp20(input logic [4:0] a, input logic oe);
        if (!oe) return 32'hFFFF_FFFF;
        if (a >= 20) return 32'h0;
        return m20[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks all outputs against the model on every cycle,
    // shortly after the falling edge.
    always @(negedge clk) begin
        #2;
        chk("cyc_rd32_a", {32'h0, rd32_a}, {32'h0, exp32(raddr_a, oe_a)});
        chk("cyc_rd32_b", {32'h0, rd32_b}, {32'h0, exp32(raddr_b, oe_b)});
        chk("cyc_rd20_a", {32'h0, rd20_a}, {32'h0, exp20(raddr_a, oe_a)});
        chk("cyc_rd20_b", {32'h0, rd20_b}, {32'h0, exp20(raddr_b, oe_b)});
        chk("cyc_wr32", {32'h0, wr32}, {32'h0, mw32});
        chk("cyc_wr20", {44'h0, wr20}, {44'h0, mw20});
    end

    // Called at falling edge + 1; returns at the next falling edge + 1.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; wmask = m;
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        mdl_clear();
        clr_n = 1'b0; sclr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
        raddr_a = 5'd5; raddr_b = 5'd5; oe_a = 1'b1; oe_b = 1'b1;
        #2;
        chk("reset_rd_a", {32'h0, rd32_a}, 64'h0);
        chk("reset_written", {32'h0, wr32}, 64'h0);
        @(negedge clk);
        #3 clr_n = 1'b1;
        @(negedge clk);
        #1;

        // Full-word write, both ports reading the same address.
        wr(5'd5, 32'hDEAD_BEEF, 4'hF);
        raddr_a = 5'd5; raddr_b = 5'd5;
        #1;
        chk("full_word_a", {32'h0, rd32_a}, 64'hDEAD_BEEF);
        chk("full_word_b", {32'h0, rd32_b}, 64'hDEAD_BEEF);
        chk("written5", {63'h0, wr32[5]}, 64'h1);

        // Byte-lane merge.
        wr(5'd7, 32'h1122_3344, 4'hF);
        wr(5'd7, 32'hAABB_CCDD, 4'h5);
        raddr_a = 5'd7;
        #1 chk("byte_lane", {32'h0, rd32_a}, 64'h11BB_33DD);

        // Register 0 is hardwired to zero.
        wr(5'd0, 32'hFFFF_FFFF, 4'hF);
        raddr_a = 5'd0;
        #1;
        chk("reg0_read", {32'h0, rd32_a}, 64'h0);
        chk("reg0_written", {63'h0, wr32[0]}, 64'h0);

        // An empty mask leaves the data unchanged but still sets the written flag.
        wr(5'd6, 32'h1234_5678, 4'h0);
        raddr_a = 5'd6;
        #1;
        chk("mask0_data", {32'h0, rd32_a}, 64'h0);
        chk("mask0_written", {63'h0, wr32[6]}, 64'h1);

        // Output enable gates the drive only; the read path itself is combinational.
        wr(5'd3, 32'h1234_5678, 4'hF);
        raddr_a = 5'd3; oe_a = 1'b0;
        #1 chk("oe_off_float", {32'h0, rd32_a}, 64'hFFFF_FFFF);
        oe_a = 1'b1;
        #1 chk("oe_on", {32'h0, rd32_a}, 64'h1234_5678);
        #2;

        // sclr takes priority over a simultaneous write.
        sclr = 1'b1;
        wr(5'd9, 32'h1, 4'hF);
        sclr = 1'b0;
        raddr_a = 5'd9; raddr_b = 5'd5;
        #1;
        chk("sclr_reg9", {32'h0, rd32_a}, 64'h0);
        chk("sclr_reg5", {32'h0, rd32_b}, 64'h0);
        chk("sclr_written", {32'h0, wr32}, 64'h0);

        // Fill every register, then apply an asynchronous clear between clock edges.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA500_0000 | i, 4'hF);
        raddr_a = 5'd31;
        #1 chk("fill_31", {32'h0, rd32_a}, 64'hA500_001F);
        #1 clr_n = 1'b0;
        #1;
        chk("async_rd", {32'h0, rd32_a}, 64'h0);
        chk("async_written", {32'h0, wr32}, 64'h0);
        // A write attempted while reset is held is ignored.
        wr(5'd4, 32'hCAFE_F00D, 4'hF);
        raddr_a = 5'd4;
        #1 chk("write_in_reset", {32'h0, rd32_a}, 64'h0);
        #1 clr_n = 1'b1;
        @(negedge clk);
        #1;

        // Out-of-range writes and reads on the DEPTH=20 instance.
        wr(5'd25, 32'h5555_AAAA, 4'hF);
        raddr_a = 5'd25;
        #1;
        chk("d20_oor_read", {32'h0, rd20_a}, 64'h0);
        chk("d20_oor_written", {44'h0, wr20}, 64'h0);
        chk("d32_addr25", {32'h0, rd32_a}, 64'h5555_AAAA);

        // Randomised traffic, checked each cycle by the compare process.
        for (int n = 0; n < 2000; n++) begin
            we      = ($urandom_range(0, 3) != 0);
            waddr   = 5'($urandom);
            wdata   = $urandom;
            wmask   = 4'($urandom);
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 5'($urandom);
            oe_a    = ($urandom_range(0, 5) != 0);
            oe_b    = ($urandom_range(0, 5) != 0);
            sclr    = ($urandom_range(0, 40) == 0);
            clr_n   = ($urandom_range(0, 60) != 0);
            @(negedge clk);
            #1;
        end
        clr_n = 1'b1;
        @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
